// File: rtl/fetch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Bundles the instruction-memory bus, the redirect input and the
//            instruction valid/ready port of the fetch stage.
// Modports : master - fetch unit side (drives imem_req/imem_addr and the
//                     instr_* outputs)
//            slave  - memory + cpu side (drives imem_rdata, redirect_*,
//                     instr_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the PC, reads a synchronous
//            instruction memory (1-cycle latency), buffers words in a
//            DEPTH-entry prefetch FIFO and presents them on a valid/ready
//            port. A redirect flushes the FIFO and restarts fetch.
// Ports    : clk, rst (async, active-high)
//            bus (fetch_unit_if.master): imem_req/imem_addr/imem_rdata,
//              redirect_valid/redirect_pc, instr_valid/instr_data/instr_pc/
//              instr_ready
//            stall_cycles[15:0] - only when FETCH_PERF_EN is defined;
//              saturating count of cycles with instr_valid & ~instr_ready
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic               r_inflight;
  logic [INSTR_W-1:0] r_fifo_data [DEPTH];
  logic [ADDR_W-1:0]  r_fifo_pc   [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_req;
  logic [CNT_W:0]     w_pending;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.instr_ready;
  // A response returning in a redirect cycle belongs to the old path. The
  // issue-cycle case needs no extra state: no request goes out while
  // redirect_valid is high, so r_inflight itself acts as the kill flag.
  assign w_push  = r_inflight & ~bus.redirect_valid;

  // Slots already promised (stored + in flight) after this cycle's pop.
  assign w_pending = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight}
                   - {{CNT_W{1'b0}}, w_pop};
  assign w_req     = ~rst & ~bus.redirect_valid
                   & (w_pending < (CNT_W+1)'(DEPTH));

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr_data  = r_fifo_data[r_rd_ptr];
  assign bus.instr_pc    = r_fifo_pc[r_rd_ptr];

  // PC and in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_inflight_pc <= r_fetch_pc;
      end
      if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc;
      end else if (w_req) begin
        r_fetch_pc <= r_fetch_pc + 1'b1;  // wraps modulo 2^ADDR_W
      end
    end
  end

  // Prefetch FIFO. Storage is reset so the head reads as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Flush wins over any same-cycle handshake.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bus.imem_rdata;
        r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_valid & ~bus.instr_ready & (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. Two instances: u_dut0
//            (RESET_PC=0x00) exercises streaming, backpressure, redirects and
//            mid-run reset; u_dut1 (RESET_PC=0xFE) streams across the PC wrap.
//            Memory model returns 0x1000 + address one cycle after a request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 2;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus0 ();
  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus1 ();

`ifdef FETCH_PERF_EN
  logic [15:0] stall0;
  logic [15:0] stall1;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
`ifdef FETCH_PERF_EN
    , .stall_cycles (stall0)
`endif
  );

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(8'hFE)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
`ifdef FETCH_PERF_EN
    , .stall_cycles (stall1)
`endif
  );

  // Synchronous instruction memory: mem[a] = 0x1000 + a.
  always @(posedge clk) begin
    if (bus0.imem_req) bus0.imem_rdata <= 16'h1000 + 16'(bus0.imem_addr);
    if (bus1.imem_req) bus1.imem_rdata <= 16'h1000 + 16'(bus1.imem_addr);
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboards of expected delivered PCs; data is implied by the memory map.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] e0;
  logic [7:0] e1;
  int n0 = 0;
  int n1 = 0;

  task automatic load0(input logic [7:0] start, input int n);
    q0.delete();
    for (int i = 0; i < n; i++) q0.push_back(start + 8'(i));
  endtask

  task automatic load1(input logic [7:0] start, input int n);
    q1.delete();
    for (int i = 0; i < n; i++) q1.push_back(start + 8'(i));
  endtask

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus0.instr_valid && bus0.instr_ready) begin
      if (q0.size() == 0) begin
        chk("hs0_unexpected_pc", 32'(bus0.instr_pc), 32'hFFFF_FFFF);
      end else begin
        e0 = q0.pop_front();
        chk("hs0_pc", 32'(bus0.instr_pc), 32'(e0));
        chk("hs0_data", 32'(bus0.instr_data), 32'h1000 + 32'(e0));
        n0++;
      end
    end
    if (!rst1 && bus1.instr_valid && bus1.instr_ready) begin
      if (q1.size() == 0) begin
        chk("hs1_unexpected_pc", 32'(bus1.instr_pc), 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        chk("hs1_pc", 32'(bus1.instr_pc), 32'(e1));
        chk("hs1_data", 32'(bus1.instr_data), 32'h1000 + 32'(e1));
        n1++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] head_pc;
  int k;

  initial begin
    rst  = 1'b1;
    rst1 = 1'b1;
    bus0.instr_ready    = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc    = '0;
    bus1.instr_ready    = 1'b1;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = '0;
    repeat (3) step();

    // Reset state
    chk("rst_req",    32'(bus0.imem_req),    32'h0);
    chk("rst_addr",   32'(bus0.imem_addr),   32'h0);
    chk("rst_valid",  32'(bus0.instr_valid), 32'h0);
    chk("rst_data",   32'(bus0.instr_data),  32'h0);
    chk("rst_pc",     32'(bus0.instr_pc),    32'h0);
    chk("rst1_addr",  32'(bus1.imem_addr),   32'hFE);
`ifdef FETCH_PERF_EN
    chk("rst_stall",  32'(stall0),           32'h0);
`endif

    // 1. Reset release and streaming
    load0(8'h00, 200);
    load1(8'hFE, 400);
    rst  = 1'b0;
    rst1 = 1'b0;
    bus0.instr_ready = 1'b1;
    #1;
    chk("c0_req",  32'(bus0.imem_req),  32'h1);
    chk("c0_addr", 32'(bus0.imem_addr), 32'h0);
    step();
    chk("c1_valid", 32'(bus0.instr_valid), 32'h0);
    step();
    chk("c2_valid", 32'(bus0.instr_valid), 32'h1);
    chk("c2_pc",    32'(bus0.instr_pc),    32'h0);
    chk("c2_data",  32'(bus0.instr_data),  32'h1000);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("stream_valid", 32'(bus0.instr_valid), 32'h1);
    end
    chk("stream_count", 32'(n0), 32'd8);

    // 2. Backpressure for 10 cycles
    bus0.instr_ready = 1'b0;
    #1;
    head_pc = q0[0];
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(bus0.instr_valid), 32'h1);
      chk("bp_pc",    32'(bus0.instr_pc),    32'(head_pc));
      chk("bp_data",  32'(bus0.instr_data),  32'h1000 + 32'(head_pc));
      chk("bp_req",   32'(bus0.imem_req),    32'h0);
      step();
    end
`ifdef FETCH_PERF_EN
    chk("bp_stall", 32'(stall0), 32'd10);
`endif
    bus0.instr_ready = 1'b1;
    repeat (6) step();
    chk("bp_release_count", 32'(n0), 32'd14);

    // 3. Single redirect to 0x40
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 8'h40;
    #1;
    chk("rd_t_req", 32'(bus0.imem_req), 32'h0);
    step();
    bus0.redirect_valid = 1'b0;
    load0(8'h40, 200);
    #1;
    chk("rd_t1_valid", 32'(bus0.instr_valid), 32'h0);
    chk("rd_t1_req",   32'(bus0.imem_req),    32'h1);
    chk("rd_t1_addr",  32'(bus0.imem_addr),   32'h40);
    step();
    chk("rd_t2_valid", 32'(bus0.instr_valid), 32'h0);
    step();
    chk("rd_t3_valid", 32'(bus0.instr_valid), 32'h1);
    chk("rd_t3_pc",    32'(bus0.instr_pc),    32'h40);
    chk("rd_t3_data",  32'(bus0.instr_data),  32'h1040);
    repeat (4) step();

    // 4. Back-to-back redirects 0x40 then 0x80
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 8'h40;
    step();
    bus0.redirect_pc = 8'h80;
    q0.delete();
    #1;
    chk("rr_t1_req",   32'(bus0.imem_req),    32'h0);
    chk("rr_t1_valid", 32'(bus0.instr_valid), 32'h0);
    step();
    bus0.redirect_valid = 1'b0;
    load0(8'h80, 200);
    #1;
    chk("rr_t2_req",   32'(bus0.imem_req),    32'h1);
    chk("rr_t2_addr",  32'(bus0.imem_addr),   32'h80);
    chk("rr_t2_valid", 32'(bus0.instr_valid), 32'h0);
    step();
    chk("rr_t3_valid", 32'(bus0.instr_valid), 32'h0);
    step();
    chk("rr_t4_valid", 32'(bus0.instr_valid), 32'h1);
    chk("rr_t4_pc",    32'(bus0.instr_pc),    32'h80);
    repeat (4) step();

    // 5. Wrap instance has delivered at least 0xFE, 0xFF, 0x00, 0x01
    chk("wrap_count", 32'(n1 >= 4), 32'h1);
    bus1.instr_ready = 1'b0;

    // 6. Mid-run reset, stall counting
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(bus0.instr_valid), 32'h0);
    chk("mrst_req",   32'(bus0.imem_req),    32'h0);
    chk("mrst_addr",  32'(bus0.imem_addr),   32'h0);
`ifdef FETCH_PERF_EN
    chk("mrst_stall", 32'(stall0), 32'h0);
`endif
    step();
    bus0.instr_ready = 1'b0;
    load0(8'h00, 200);
    rst = 1'b0;
    k = 0;
    while (!bus0.instr_valid && k < 10) begin
      step();
      k++;
    end
    chk("mrst_valid_timeout", 32'(bus0.instr_valid), 32'h1);
    repeat (5) step();
    chk("stall_head_pc",   32'(bus0.instr_pc),   32'h0);
    chk("stall_head_data", 32'(bus0.instr_data), 32'h1000);
`ifdef FETCH_PERF_EN
    chk("stall_5", 32'(stall0), 32'd5);
    rst = 1'b1;
    #1;
    chk("stall_rst", 32'(stall0), 32'h0);
    step();
    rst = 1'b0;
    k = 0;
    while (!bus0.instr_valid && k < 10) begin
      step();
      k++;
    end
    chk("sat_valid_timeout", 32'(bus0.instr_valid), 32'h1);
    repeat (70000) step();
    chk("stall_sat", 32'(stall0), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
